// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the core's single-port data memory.
// Port 0 is the load/store unit, port 1 the loader; read data returns one cycle after grant.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_we,
    input  logic [1:0]          req_lock,
    input  logic [ADDR_W-1:0]   req_addr0,
    input  logic [ADDR_W-1:0]   req_addr1,
    input  logic [DATA_W-1:0]   req_wdata0,
    input  logic [DATA_W-1:0]   req_wdata1,
    input  logic [DATA_W/8-1:0] req_be0,
    input  logic [DATA_W/8-1:0] req_be1,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

    logic       owner_vld;
    logic       owner_id;
    logic       rr_ptr;
    logic [7:0] lock_cnt;
    logic [1:0] rsp_vld_p1;

    logic       gnt_vld_p0;
    logic       gnt_id_p0;
    logic       starved;
    logic       hold;

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        if (cnt >= LOCK_MAX)
            return LOCK_MAX;
        return cnt + 8'd1;
    endfunction

    // Stage p0: grant selection and memory request mux
    always_comb begin
        starved    = owner_vld && (lock_cnt == LOCK_MAX) && req_valid[~owner_id];
        hold       = owner_vld && req_valid[owner_id] && !starved;
        gnt_vld_p0 = 1'b0;
        gnt_id_p0  = 1'b0;
        if (reset) begin
            if (hold) begin
                gnt_vld_p0 = 1'b1;
                gnt_id_p0  = owner_id;
            end else if (starved) begin
                // A starved owner must yield to the waiting port regardless of rr_ptr.
                gnt_vld_p0 = 1'b1;
                gnt_id_p0  = ~owner_id;
            end else begin
                unique case (req_valid)
                    2'b01: begin gnt_vld_p0 = 1'b1; gnt_id_p0 = 1'b0;   end
                    2'b10: begin gnt_vld_p0 = 1'b1; gnt_id_p0 = 1'b1;   end
                    2'b11: begin gnt_vld_p0 = 1'b1; gnt_id_p0 = rr_ptr; end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        req_ready = 2'b00;
        mem_en    = gnt_vld_p0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (gnt_vld_p0) begin
            req_ready[gnt_id_p0] = 1'b1;
            mem_we    = req_we[gnt_id_p0];
            mem_addr  = gnt_id_p0 ? req_addr1  : req_addr0;
            mem_wdata = gnt_id_p0 ? req_wdata1 : req_wdata0;
            mem_be    = gnt_id_p0 ? req_be1    : req_be0;
        end
    end

    // Stage p1: arbitration state and read-response routing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_vld  <= 1'b0;
            owner_id   <= 1'b0;
            rr_ptr     <= 1'b0;
            lock_cnt   <= 8'd0;
            rsp_vld_p1 <= 2'b00;
        end else if (gnt_vld_p0) begin
            owner_vld  <= req_lock[gnt_id_p0];
            owner_id   <= gnt_id_p0;
            lock_cnt   <= (owner_vld && owner_id == gnt_id_p0) ? sat_inc(lock_cnt) : 8'd1;
            rr_ptr     <= ~gnt_id_p0;
            rsp_vld_p1 <= req_we[gnt_id_p0] ? 2'b00 : (gnt_id_p0 ? 2'b10 : 2'b01);
        end else begin
            owner_vld  <= 1'b0;
            lock_cnt   <= 8'd0;
            rsp_vld_p1 <= 2'b00;
        end
    end

    assign rsp_valid = rsp_vld_p1;
    assign rsp_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter with MAX_LOCK = 4,
// checked against a grant-history reference model and a byte-level memory model.
module tb_dmem_arbiter;

    localparam int MAXL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_we, req_lock;
    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    logic [3:0]  be   [2];
    logic [1:0]  req_ready, rsp_valid;
    logic [31:0] rsp_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = 32'd0;

    logic [31:0] mem     [256] = '{default: 32'd0};
    logic [31:0] ref_mem [256] = '{default: 32'd0};

    typedef struct {
        int g;
        bit lk;
    } ent_t;

    ent_t        hist [$];
    int          rr;
    int          exp_rsp_port;
    logic [31:0] exp_rsp_data;
    int          last_g;
    int          checks;
    int          errors;
    logic [1:0]  obs_ready, obs_rsp_v;
    logic [31:0] obs_rdata;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(MAXL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_lock(req_lock),
        .req_addr0(addr[0]), .req_addr1(addr[1]),
        .req_wdata0(wdat[0]), .req_wdata1(wdat[1]),
        .req_be0(be[0]), .req_be1(be[1]),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[mem_addr[9:2]];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected grant from the rules: lock hold unless starved, otherwise single valid or round robin.
    function automatic int pick();
        int  own;
        int  run;
        int  n;
        bit  starve;
        if (!reset) return -1;
        own = -1;
        run = 0;
        if (hist.size() > 0 && hist[hist.size()-1].g >= 0 && hist[hist.size()-1].lk)
            own = hist[hist.size()-1].g;
        if (own >= 0) begin
            n   = hist.size() - 1;
            run = 1;
            while (n > 0 && hist[n-1].g == own && hist[n-1].lk) begin
                run++;
                n--;
            end
        end
        starve = (own >= 0) && (run >= MAXL) && req_valid[1-own];
        if (own >= 0 && req_valid[own] && !starve) return own;
        if (req_valid == 2'b11) return starve ? 1 - own : rr;
        if (req_valid[0]) return 0;
        if (req_valid[1]) return 1;
        return -1;
    endfunction

    task automatic ref_write(input int p);
        for (int b = 0; b < 4; b++)
            if (be[p][b]) ref_mem[addr[p][9:2]][8*b +: 8] = wdat[p][8*b +: 8];
    endtask

    task automatic step();
        int         g;
        logic [1:0] er;
        logic [1:0] ev;
        ent_t       e;
        #1;
        g         = pick();
        obs_ready = req_ready;
        obs_rsp_v = rsp_valid;
        obs_rdata = rsp_rdata;
        er = (g < 0) ? 2'b00 : 2'(1 << g);
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("mem_en", 64'(mem_en), 64'(g >= 0));
        if (g >= 0) begin
            chk("mem_we",    64'(mem_we),    64'(req_we[g]));
            chk("mem_addr",  64'(mem_addr),  64'(addr[g]));
            chk("mem_wdata", 64'(mem_wdata), 64'(wdat[g]));
            chk("mem_be",    64'(mem_be),    64'(be[g]));
        end else if (!reset) begin
            chk("rst_mem_bus", 64'({mem_we, mem_addr, mem_be}), 64'd0);
            chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        end
        ev = (!reset || exp_rsp_port < 0) ? 2'b00 : 2'(1 << exp_rsp_port);
        chk("rsp_valid", 64'(rsp_valid), 64'(ev));
        if (ev != 2'b00) chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rsp_data));
        if (!reset) begin
            hist.delete();
            rr           = 0;
            exp_rsp_port = -1;
        end else begin
            e.g  = g;
            e.lk = (g >= 0) && req_lock[g];
            hist.push_back(e);
            if (hist.size() > 32) void'(hist.pop_front());
            exp_rsp_port = -1;
            if (g >= 0) begin
                rr = 1 - g;
                if (req_we[g]) ref_write(g);
                else begin
                    exp_rsp_port = g;
                    exp_rsp_data = ref_mem[addr[g][9:2]];
                end
            end
        end
        last_g = g;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic req(input int p, input logic we, input logic lk, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
        req_valid[p] = 1'b1;
        req_we[p]    = we;
        req_lock[p]  = lk;
        addr[p]      = a;
        wdat[p]      = d;
        be[p]        = b;
    endtask

    task automatic idle(input int p);
        req_valid[p] = 1'b0;
        req_lock[p]  = 1'b0;
    endtask

    task automatic rst_pulse();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        logic [1:0] t3 [6];
        logic [1:0] t4 [6];
        t3 = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        t4 = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        checks       = 0;
        errors       = 0;
        rr           = 0;
        exp_rsp_port = -1;
        exp_rsp_data = 32'd0;
        last_g       = -1;
        reset        = 1'b0;
        req_valid    = 2'b00;
        req_we       = 2'b00;
        req_lock     = 2'b00;
        for (int p = 0; p < 2; p++) begin
            addr[p] = 32'd0;
            wdat[p] = 32'd0;
            be[p]   = 4'd0;
        end

        // Reset, then idle
        #25;
        step();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) step();

        // Single-port write by loader, then core read
        req(1, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'hF);
        step();
        chk("t2_wr_ready", 64'(obs_ready), 64'(2'b10));
        idle(1);
        req(0, 1'b0, 1'b0, 32'h100, 32'h0, 4'hF);
        step();
        chk("t2_rd_ready", 64'(obs_ready), 64'(2'b01));
        idle(0);
        step();
        chk("t2_rsp_valid", 64'(obs_rsp_v), 64'(2'b01));
        chk("t2_rsp_rdata", 64'(obs_rdata), 64'(32'hDEADBEEF));

        // Contention without lock alternates starting at port 0
        rst_pulse();
        req(0, 1'b0, 1'b0, 32'h100, 32'h0, 4'hF);
        req(1, 1'b0, 1'b0, 32'h104, 32'h0, 4'hF);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("t3_gnt%0d", i), 64'(obs_ready), 64'(t3[i]));
        end
        idle(0);
        idle(1);
        step();

        // Locked loader is capped at MAX_LOCK grants while the core waits
        rst_pulse();
        req(0, 1'b1, 1'b0, 32'h300, 32'h5A5A5A5A, 4'hF);
        step();
        idle(0);
        req(1, 1'b0, 1'b1, 32'h104, 32'h0, 4'hF);
        req(0, 1'b0, 1'b0, 32'h108, 32'h0, 4'hF);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("t4_gnt%0d", i), 64'(obs_ready), 64'(t4[i]));
        end
        idle(0);
        idle(1);
        step();
        step();

        // Byte-enable merge
        req(0, 1'b1, 1'b0, 32'h200, 32'h11223344, 4'hF);
        step();
        req(0, 1'b1, 1'b0, 32'h200, 32'h000000AA, 4'b0001);
        step();
        req(0, 1'b0, 1'b0, 32'h200, 32'h0, 4'hF);
        step();
        idle(0);
        step();
        chk("t5_rsp_valid", 64'(obs_rsp_v), 64'(2'b01));
        chk("t5_rsp_rdata", 64'(obs_rdata), 64'(32'h112233AA));

        // Reset lands while a read response is pending
        req(0, 1'b0, 1'b0, 32'h200, 32'h0, 4'hF);
        step();
        chk("t6_rd_ready", 64'(obs_ready), 64'(2'b01));
        idle(0);
        reset = 1'b0;
        step();
        chk("t6_rsp_dropped", 64'(obs_rsp_v), 64'(2'b00));
        reset = 1'b1;
        req(0, 1'b0, 1'b0, 32'h100, 32'h0, 4'hF);
        req(1, 1'b0, 1'b0, 32'h104, 32'h0, 4'hF);
        step();
        chk("t6_first_gnt", 64'(obs_ready), 64'(2'b01));
        idle(0);
        idle(1);
        step();
        step();

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            for (int p = 0; p < 2; p++) begin
                if (!req_valid[p] || last_g == p) begin
                    if ($urandom_range(0, 99) < 70)
                        req(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            {22'd0, 8'($urandom_range(0, 15)), 2'b00}, $urandom,
                            4'($urandom_range(1, 15)));
                    else
                        idle(p);
                end
            end
            step();
        end
        reset = 1'b1;
        idle(0);
        idle(1);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
